// File: rtl/i2c_pkg.sv
// Shared types and frame constants for the I2C frame writer.
package i2c_pkg;

    localparam int STATE_W          = 3;
    localparam int QUARTERS_PER_BIT = 4;
    localparam int BITS_PER_BYTE    = 8;
    localparam int BYTES_PER_FRAME  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period tick generator: one-cycle tick every CLK_DIV cycles while enabled.
module i2c_quarter_tick #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clock_50,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam logic [9:0] CNT_LAST = 10'(CLK_DIV - 1);
    localparam logic [9:0] CNT_PRE  = 10'(CLK_DIV - 2);

    logic [9:0] cnt_r;
    logic       tick_r;

    // Counter held at zero while disabled; tick registered one cycle ahead so it lines up with CNT_LAST.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r  <= 10'd0;
            tick_r <= 1'b0;
        end else if (!enable) begin
            cnt_r  <= 10'd0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= (cnt_r == CNT_LAST) ? 10'd0 : cnt_r + 10'd1;
            tick_r <= (cnt_r == CNT_PRE);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/i2c_frame_writer.sv
// Open-drain I2C master writing one 3-byte frame {addr, reg, data}.
// Optional macro I2C_ACK_CHECK_EN: a NACK sets ack_error and aborts straight to STOP.
module i2c_frame_writer
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic        clock_50,
    input  logic        reset_n,
    input  logic        start,
    input  logic [23:0] i2c_data,
    output logic        busy,
    output logic        done,
    output logic        ack_error,
    output logic        i2c_serial_clock,
    inout  wire         i2c_serial_data
);

`ifdef I2C_ACK_CHECK_EN
    localparam logic ACK_CHECK = 1'b1;
`else
    localparam logic ACK_CHECK = 1'b0;
`endif

    localparam logic [1:0] Q_LAST    = 2'(QUARTERS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST  = 3'(BITS_PER_BYTE - 1);
    localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_FRAME - 1);

    state_t      state_r;
    logic [1:0]  q_r;
    logic [2:0]  bit_cnt_r;
    logic [1:0]  byte_cnt_r;
    logic [23:0] shift_r;
    logic        nack_r;
    logic        busy_r;
    logic        done_r;
    logic        ack_error_r;
    logic        scl_r;
    logic        sda_low_r;
    logic        tick_s;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .enable   (busy_r),
        .tick     (tick_s)
    );

    // Frame sequencer; SCL/SDA registers hold the levels of the quarter being entered.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            q_r         <= 2'd0;
            bit_cnt_r   <= 3'd0;
            byte_cnt_r  <= 2'd0;
            shift_r     <= 24'd0;
            nack_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ack_error_r <= 1'b0;
            scl_r       <= 1'b1;
            sda_low_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        shift_r     <= i2c_data;
                        ack_error_r <= 1'b0;
                        nack_r      <= 1'b0;
                        busy_r      <= 1'b1;
                        q_r         <= 2'd0;
                        bit_cnt_r   <= 3'd0;
                        byte_cnt_r  <= 2'd0;
                        scl_r       <= 1'b1;
                        sda_low_r   <= 1'b0;
                        state_r     <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        q_r <= q_r + 2'd1;
                        case (q_r)
                            2'd0:    sda_low_r <= 1'b1;
                            2'd1:    scl_r     <= 1'b0;
                            Q_LAST: begin
                                sda_low_r <= ~shift_r[23];
                                state_r   <= ST_BIT;
                            end
                            default: begin end
                        endcase
                    end
                end
                ST_BIT: begin
                    if (tick_s) begin
                        q_r <= q_r + 2'd1;
                        case (q_r)
                            2'd0:    scl_r <= 1'b1;
                            2'd2:    scl_r <= 1'b0;
                            Q_LAST: begin
                                shift_r <= {shift_r[22:0], 1'b0};
                                if (bit_cnt_r == BIT_LAST) begin
                                    bit_cnt_r <= 3'd0;
                                    sda_low_r <= 1'b0;
                                    state_r   <= ST_ACK;
                                end else begin
                                    bit_cnt_r <= bit_cnt_r + 3'd1;
                                    sda_low_r <= ~shift_r[22];
                                end
                            end
                            default: begin end
                        endcase
                    end
                end
                ST_ACK: begin
                    if (tick_s) begin
                        q_r <= q_r + 2'd1;
                        case (q_r)
                            2'd0: scl_r <= 1'b1;
                            // Acknowledge is sampled at the end of the second high quarter.
                            2'd2: begin
                                scl_r  <= 1'b0;
                                nack_r <= ACK_CHECK & i2c_serial_data;
                                if (ACK_CHECK & i2c_serial_data) begin
                                    ack_error_r <= 1'b1;
                                end
                            end
                            Q_LAST: begin
                                if ((byte_cnt_r == BYTE_LAST) || nack_r) begin
                                    sda_low_r <= 1'b1;
                                    state_r   <= ST_STOP;
                                end else begin
                                    byte_cnt_r <= byte_cnt_r + 2'd1;
                                    sda_low_r  <= ~shift_r[23];
                                    state_r    <= ST_BIT;
                                end
                            end
                            default: begin end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick_s) begin
                        q_r <= q_r + 2'd1;
                        case (q_r)
                            2'd0:    scl_r     <= 1'b1;
                            2'd1:    sda_low_r <= 1'b0;
                            Q_LAST: begin
                                byte_cnt_r <= 2'd0;
                                nack_r     <= 1'b0;
                                busy_r     <= 1'b0;
                                done_r     <= 1'b1;
                                state_r    <= ST_DONE;
                            end
                            default: begin end
                        endcase
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    scl_r     <= 1'b1;
                    sda_low_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign ack_error        = ack_error_r;
    assign i2c_serial_clock = scl_r;
    assign i2c_serial_data  = sda_low_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_frame_writer.sv
// Bench for i2c_frame_writer: quarter-level timing model, bus-level byte decoder with ACKing slave.
`timescale 1ns/1ps
module tb_i2c_frame_writer;

    localparam int CLK_DIV = 4;

    logic        clock_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        start    = 1'b0;
    logic [23:0] i2c_data = 24'h0;
    logic        busy, done, ack_error, i2c_serial_clock;
    wire         i2c_serial_data;
    logic        slave_low = 1'b0;

    pullup (i2c_serial_data);
    assign i2c_serial_data = slave_low ? 1'b0 : 1'bz;

    i2c_frame_writer #(.CLK_DIV(CLK_DIV)) dut (
        .clock_50         (clock_50),
        .reset_n          (reset_n),
        .start            (start),
        .i2c_data         (i2c_data),
        .busy             (busy),
        .done             (done),
        .ack_error        (ack_error),
        .i2c_serial_clock (i2c_serial_clock),
        .i2c_serial_data  (i2c_serial_data)
    );

    always #10 clock_50 = ~clock_50;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clock_50) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timing model: a frame is 4 START quarters, 9 slots of 4 quarters per byte, 4 STOP quarters.
    bit model_on = 1'b0;
    int entry    = 0;
    int nquart   = 0;
    int exp_nb   = 0;
    bit exp_err  = 1'b0;

    function automatic logic exp_scl(input int k, input int nb);
        int q, body, r;
        q    = k / 4;
        body = nb * 36;
        if (q < 4) return (q < 2);
        if (q < 4 + body) begin
            r = (q - 4) % 4;
            return (r == 1) || (r == 2);
        end
        if (q < 8 + body) return ((q - 4 - body) >= 1);
        return 1'b1;
    endfunction

    always @(negedge clock_50) begin
        int k;
        if (model_on && reset_n) begin
            k = cyc - entry;
            if (k >= 0) begin
                check("busy", busy, k < nquart * 4);
                check("done", done, k == nquart * 4);
                check("scl", i2c_serial_clock, exp_scl(k, exp_nb));
                if (k < 4) check("ack_error_cleared", ack_error, 0);
                if (k >= nquart * 4) check("ack_error_final", ack_error, exp_err);
            end
        end
    end

    // Bus monitor and slave: decodes bytes on SCL rising edges, ACKs unless told to NACK.
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    int   bitpos   = 0;
    logic [7:0] acc = 8'h0;
    logic [7:0] rx_bytes[$];
    logic       rx_acks[$];
    int   starts   = 0;
    int   stops    = 0;
    bit   mon_on   = 1'b0;
    int   nack_byte = -1;

    always @(negedge clock_50) begin
        logic s, d;
        s = i2c_serial_clock;
        d = i2c_serial_data;
        if (mon_on) begin
            if (prev_scl && s && (d !== prev_sda)) begin
                if (!d) starts++;
                else    stops++;
                bitpos = 0;
            end else if (!prev_scl && s) begin
                if (bitpos < 8) begin
                    acc = {acc[6:0], d};
                    bitpos++;
                end else begin
                    rx_bytes.push_back(acc);
                    rx_acks.push_back(d);
                    bitpos = 0;
                end
            end else if (prev_scl && !s) begin
                slave_low = (bitpos == 8) && (rx_bytes.size() != nack_byte);
            end
        end
        prev_scl = s;
        prev_sda = d;
    end

    // Called on a negedge; start is sampled on the following posedge.
    task automatic launch(input logic [23:0] data, input int nack);
        rx_bytes.delete();
        rx_acks.delete();
        starts    = 0;
        stops     = 0;
        bitpos    = 0;
        nack_byte = nack;
`ifdef I2C_ACK_CHECK_EN
        exp_nb  = (nack >= 0) ? nack + 1 : 3;
        exp_err = (nack >= 0);
`else
        exp_nb  = 3;
        exp_err = 1'b0;
`endif
        nquart   = 8 + exp_nb * 36;
        entry    = cyc + 1;
        model_on = 1'b1;
        mon_on   = 1'b1;
        i2c_data = data;
        start    = 1'b1;
        @(negedge clock_50);
        start    = 1'b0;
        i2c_data = ~data;
    endtask

    task automatic wait_done(input int exp_lat, input int ign_at);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 2000) begin
            if (ign_at >= 0 && (cyc - entry) == ign_at) begin
                start    = 1'b1;
                i2c_data = 24'h5A5A5A;
            end else begin
                start = 1'b0;
            end
            @(negedge clock_50);
            n++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end else begin
            check("latency", cyc - entry, exp_lat);
        end
    endtask

    task automatic verify(input logic [23:0] data, input int nack);
        logic [23:0] d;
        d = data;
        check("nbytes", rx_bytes.size(), exp_nb);
        for (int i = 0; i < exp_nb && i < rx_bytes.size(); i++) begin
            check("byte", rx_bytes[i], d[23 - 8 * i -: 8]);
            check("ack_bit", rx_acks[i], (i == nack));
        end
        check("start_cond", starts, 1);
        check("stop_cond", stops, 1);
        check("ack_error", ack_error, exp_err);
    endtask

    initial begin
        repeat (3) @(negedge clock_50);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_error", ack_error, 0);
        check("rst_scl", i2c_serial_clock, 1);
        check("rst_sda", i2c_serial_data, 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clock_50);

        // Plain ACKed frame.
        launch(24'h729803, -1);
        wait_done(464, -1);
        verify(24'h729803, -1);
        check("lit_byte0", rx_bytes.size() > 0 ? rx_bytes[0] : 8'h00, 8'h72);
        check("lit_byte2", rx_bytes.size() > 2 ? rx_bytes[2] : 8'h00, 8'h03);

        // Start during DONE is ignored, start in the first IDLE cycle is accepted.
        start    = 1'b1;
        i2c_data = 24'h111111;
        @(negedge clock_50);
        start = 1'b0;
        check("done_start_ignored", busy, 0);
        launch(24'h729803, -1);
        wait_done(464, 100);
        verify(24'h729803, -1);

        // Slave NACKs the address byte.
        repeat (5) @(negedge clock_50);
        launch(24'h721500, 0);
`ifdef I2C_ACK_CHECK_EN
        wait_done(176, -1);
`else
        wait_done(464, -1);
`endif
        verify(24'h721500, 0);

        // Reset in the middle of byte 1 while SCL is high and SDA is driven low.
        repeat (5) @(negedge clock_50);
        launch(24'h729803, -1);
        repeat (199) @(negedge clock_50);
        check("pre_rst_sda_low", i2c_serial_data, 0);
        model_on  = 1'b0;
        mon_on    = 1'b0;
        slave_low = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("midrst_scl", i2c_serial_clock, 1);
        check("midrst_sda", i2c_serial_data, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (2) @(negedge clock_50);
        reset_n = 1'b1;
        @(negedge clock_50);
        launch(24'h72AF16, -1);
        wait_done(464, -1);
        verify(24'h72AF16, -1);
        check("lit_af", rx_bytes.size() > 1 ? rx_bytes[1] : 8'h00, 8'hAF);

        repeat (4) @(negedge clock_50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_frame_writer.md
I2C_FRAME_WRITER -- requirements
Module: i2c_frame_writer

Interface
REQ-001 SHALL have parameter: CLK_DIV, 125, clock_50 cycles per SCL quarter-period (125 gives 100 kHz SCL from 50 MHz); legal range 2..1023.
REQ-002 SHALL have port: clock_50  input  1  the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to transmit i2c_data; sampled only in IDLE.
REQ-005 SHALL have port: i2c_data  input  24  {device address byte, register byte, data byte}; transmitted MSB first.
REQ-006 SHALL have port: busy  output  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-007 SHALL have port: done  output  1  one-cycle pulse that marks the end of a transaction.
REQ-008 SHALL have port: ack_error  output  1  set when a NACK is detected; cleared on the next accepted start.
REQ-009 SHALL have port: i2c_serial_clock  output  1  SCL; driven high when idle.
REQ-010 SHALL have port: i2c_serial_data  inout  1  SDA; open-drain: the block drives 0 or high-Z, never 1.

Function
REQ-011 SHALL generate a quarter-tick every CLK_DIV cycles; the tick counter SHALL run only while busy and SHALL restart at 0 on an accepted start.
REQ-012 SHALL implement the states IDLE, START, BIT, ACK, STOP and DONE, advancing only on quarter-ticks except IDLE->START and DONE->IDLE.
REQ-013 IDLE: on start=1, SHALL latch i2c_data into a 24-bit shift register, clear ack_error, set busy and go to START on the next cycle; start SHALL be ignored in every other state.
REQ-014 START (4 quarters): SDA SHALL be released with SCL high, then driven low with SCL high, then SCL driven low; SDA SHALL fall only while SCL is high.
REQ-015 BIT (4 quarters per bit, 8 bits per byte): q0 SCL low with SDA set to the shift-register MSB (low=drive 0, high=Z); q1 and q2 SCL high; q3 SCL low and shift left by one.
REQ-016 ACK (4 quarters): SDA released; SDA sampled at q2 with SCL high; a value of 1 is a NACK.
REQ-017 After the ACK phase of byte 0 or byte 1, the block SHALL go to BIT for the next byte; after byte 2 it SHALL go to STOP; a 2-bit byte counter SHALL track this.
REQ-018 STOP (4 quarters): SDA driven low with SCL low, SCL released high, then SDA released while SCL is high.
REQ-019 DONE SHALL last exactly one cycle: done=1 and busy=0 in that cycle, then the block returns to IDLE.
REQ-020 A full ACKed transaction SHALL take exactly 116*CLK_DIV cycles from START entry to DONE entry (4 + 3*36 + 4 quarters).
REQ-021 A start asserted in the DONE cycle SHALL be ignored; a start in the first IDLE cycle after DONE SHALL be accepted.

Reset
REQ-022 While reset_n=0: state=IDLE, SCL=1, SDA=Z, busy=0, done=0, ack_error=0, counters=0, shift register=0.
REQ-023 Reset asserted mid-transaction SHALL release SCL and SDA asynchronously, with no STOP generated; the first transaction after reset SHALL start cleanly from IDLE.

Configuration
REQ-024 Macro I2C_ACK_CHECK_EN defined: a NACK SHALL set ack_error and branch directly to STOP, skipping the remaining bytes.
REQ-025 Macro I2C_ACK_CHECK_EN undefined: the ACK bit SHALL still be clocked, but ack_error SHALL stay 0 and all 3 bytes SHALL always be sent.

Structure
REQ-026 The state enum, state width and the constants QUARTERS_PER_BIT=4, BITS_PER_BYTE=8 and BYTES_PER_FRAME=3 SHALL live in the shared package i2c_pkg.
REQ-027 The quarter-tick generator SHALL be a sub-module named i2c_quarter_tick (inputs: clock_50, reset_n, enable; output: tick); all other logic SHALL stay in i2c_frame_writer.

Verification
REQ-028 CLK_DIV=4, start with i2c_data=24'h729803, slave ACKs every byte: SDA bytes decode as 72, 98, 03; done pulses at 464 cycles; ack_error=0.
REQ-029 With I2C_ACK_CHECK_EN defined, slave NACKs byte 0 of 24'h721500: STOP follows the first ACK slot, ack_error=1, done at (4+36+4)*4=176 cycles.
REQ-030 The same NACK with the macro undefined: all 3 bytes are sent, done at 464 cycles, ack_error=0.
REQ-031 start pulsed again at cycle 100 of a busy transaction with different data: it is ignored and the original 24'h729803 completes unchanged.
REQ-032 reset_n pulled low at cycle 200 of a transfer: SCL=1 and SDA=Z in the same cycle; after release, a new start sending 24'h72AF16 completes correctly.
REQ-033 Protocol monitor over all scenarios: SDA never changes while SCL is high except for START/STOP edges; SDA is never driven to 1.
